// File: rtl/n64_tx_frame_ctrl.sv
// n64_tx_frame_ctrl
//   Sequences one N64/GameCube transmit frame over a single-bit pulse
//   transmitter: byte_count bytes sent MSB-first, followed by one stop bit.
//   Bytes arrive on a ready/valid stream. Each bit is issued as a one-cycle
//   trigger with a held digit code, then the controller waits for the
//   transmitter's busy flag to rise and fall.
//
// Ports
//   sys_clk      system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   start        begin a frame (sampled only when idle)
//   byte_count   bytes in the frame, latched on start (0 = stop bit only)
//   stop_sel     latched on start; 1 = controller stop (11), 0 = console stop (10)
//   in_valid     stream byte valid
//   in_data      stream byte
//   in_ready     stream byte accepted when in_valid & in_ready
//   bit_trigger  one-cycle pulse to the transmitter
//   bit_digit    01 one, 00 zero, 11/10 stop; held until the bit completes
//   bit_busy     transmitter transmitting flag
//   busy         frame in progress
//   done         one-cycle pulse, frame completed cleanly
//   err          01 underrun, 10 rise timeout, 11 busy timeout (held to next start)
//   err_pulse    one-cycle pulse, frame aborted or flagged
module n64_tx_frame_ctrl #(
  parameter int CNT_W        = 7,
  parameter int RISE_TIMEOUT = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             stop_sel,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             bit_trigger,
  output logic [1:0]       bit_digit,
  input  logic             bit_busy,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             err_pulse
);

  localparam int TMR_MAX = (RISE_TIMEOUT > BUSY_TIMEOUT) ? RISE_TIMEOUT : BUSY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RISE_LAST = TMR_W'(RISE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDERRUN = 2'b01;
  localparam logic [1:0] ERR_RISE     = 2'b10;
  localparam logic [1:0] ERR_BUSY     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_TRIG,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_STOP_TRIG,
    S_STOP_RISE,
    S_STOP_FALL,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bytes_left;   // bytes not yet taken from the stream
  logic             stop_sel_q;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [7:0]       pf_data;      // byte prefetched during bit 0
  logic             pf_valid;
  logic [TMR_W-1:0] tmr;

  logic             hs;
  logic [CNT_W-1:0] bytes_left_dec;

  assign hs             = in_valid & in_ready;
  assign bytes_left_dec = (bytes_left != '0) ? bytes_left - CNT_W'(1) : '0;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      bit_trigger <= 1'b0;
      bit_digit   <= 2'b01;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_NONE;
      err_pulse   <= 1'b0;
      bytes_left  <= '0;
      stop_sel_q  <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
      pf_data     <= '0;
      pf_valid    <= 1'b0;
      tmr         <= '0;
    end else begin
      bit_trigger <= 1'b0;
      done        <= 1'b0;
      err_pulse   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err        <= ERR_NONE;
            bytes_left <= byte_count;
            stop_sel_q <= stop_sel;
            pf_valid   <= 1'b0;
            if (byte_count == '0) begin
              state <= S_STOP_TRIG;
            end else begin
              state    <= S_FETCH;
              in_ready <= 1'b1;
            end
          end
        end

        // Single-cycle fetch window; an absent byte is an underrun, but the
        // stop bit is still sent so the line ends on a frame boundary.
        S_FETCH: begin
          in_ready <= 1'b0;
          if (hs) begin
            shreg      <= in_data;
            bit_idx    <= 3'd7;
            bytes_left <= bytes_left_dec;
            state      <= S_TRIG;
          end else begin
            err   <= ERR_UNDERRUN;
            state <= S_STOP_TRIG;
          end
        end

        S_TRIG: begin
          bit_digit   <= {1'b0, shreg[7]};
          bit_trigger <= 1'b1;
          tmr         <= '0;
          state       <= S_WAIT_RISE;
        end

        S_WAIT_RISE: begin
          if (bit_busy) begin
            tmr   <= '0;
            state <= S_WAIT_FALL;
            // Open the prefetch window for the whole of bit 0.
            if (bit_idx == 3'd0 && bytes_left != '0 && !pf_valid)
              in_ready <= 1'b1;
          end else if (tmr == RISE_LAST) begin
            err   <= ERR_RISE;
            state <= S_DONE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_WAIT_FALL: begin
          if (hs) begin
            pf_data    <= in_data;
            pf_valid   <= 1'b1;
            bytes_left <= bytes_left_dec;
            in_ready   <= 1'b0;
          end
          if (!bit_busy) begin
            in_ready <= 1'b0;
            if (bit_idx != 3'd0) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_idx <= bit_idx - 3'd1;
              state   <= S_TRIG;
            end else if (hs) begin
              // Byte arrived on the very cycle the bit ended: use it directly.
              shreg    <= in_data;
              bit_idx  <= 3'd7;
              pf_valid <= 1'b0;
              state    <= S_TRIG;
            end else if (pf_valid) begin
              shreg    <= pf_data;
              bit_idx  <= 3'd7;
              pf_valid <= 1'b0;
              state    <= S_TRIG;
            end else if (bytes_left != '0) begin
              in_ready <= 1'b1;
              state    <= S_FETCH;
            end else begin
              state <= S_STOP_TRIG;
            end
          end else if (tmr == BUSY_LAST) begin
            err      <= ERR_BUSY;
            in_ready <= 1'b0;
            state    <= S_DONE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_STOP_TRIG: begin
          bit_digit   <= stop_sel_q ? 2'b11 : 2'b10;
          bit_trigger <= 1'b1;
          tmr         <= '0;
          state       <= S_STOP_RISE;
        end

        S_STOP_RISE: begin
          if (bit_busy) begin
            tmr   <= '0;
            state <= S_STOP_FALL;
          end else if (tmr == RISE_LAST) begin
            err   <= ERR_RISE;
            state <= S_DONE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_STOP_FALL: begin
          if (!bit_busy) begin
            state <= S_DONE;
          end else if (tmr == BUSY_LAST) begin
            err   <= ERR_BUSY;
            state <= S_DONE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_DONE: begin
          busy <= 1'b0;
          if (err == ERR_NONE) done      <= 1'b1;
          else                 err_pulse <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_tx_frame_ctrl.sv
module tb_n64_tx_frame_ctrl;

  localparam int CNT_W   = 7;
  localparam int BIT_LEN = 200;

  logic             sys_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic [CNT_W-1:0] byte_count = '0;
  logic             stop_sel = 1'b0;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             bit_trigger;
  logic [1:0]       bit_digit;
  logic             bit_busy = 1'b0;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic             err_pulse;

  n64_tx_frame_ctrl #(.CNT_W(CNT_W), .RISE_TIMEOUT(4), .BUSY_TIMEOUT(255)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_count (byte_count),
    .stop_sel   (stop_sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bit_trigger(bit_trigger),
    .bit_digit  (bit_digit),
    .bit_busy   (bit_busy),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_pulse  (err_pulse)
  );

  always #10 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream source: bytes loaded into src_mem, consumed on handshake.
  logic [7:0] src_mem [64];
  int         src_rd  = 0;
  int         src_len = 0;
  logic       src_en  = 1'b1;

  always_comb begin
    in_valid = src_en && (src_rd < src_len);
    in_data  = src_mem[src_rd % 64];
  end

  // Transmitter stub plus event recorders.
  logic       tx_en = 1'b1;
  int         tx_cnt = 0;
  logic [1:0] tx_digit = 2'b00;
  int         trig_cnt = 0, hs_cnt = 0, done_cnt = 0, errp_cnt = 0, unstable = 0;
  logic [1:0] last_err = 2'b00;
  logic [1:0] dig_log[$];

  always @(posedge sys_clk) begin
    if (bit_trigger) begin
      trig_cnt <= trig_cnt + 1;
      dig_log.push_back(bit_digit);
    end
    if (in_valid && in_ready) begin
      hs_cnt <= hs_cnt + 1;
      src_rd <= src_rd + 1;
    end
    if (done)      done_cnt <= done_cnt + 1;
    if (err_pulse) errp_cnt <= errp_cnt + 1;
    if (done || err_pulse) last_err <= err;
    if (bit_busy && rst_n && bit_digit != tx_digit) unstable <= unstable + 1;
    if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) bit_busy <= 1'b0;
    end else if (bit_trigger && tx_en) begin
      bit_busy <= 1'b1;
      tx_cnt   <= BIT_LEN;
      tx_digit <= bit_digit;
    end
  end

  // Per-frame results
  int f_trig, f_hs, f_done, f_errp, f_cycles, f_log0;
  logic [1:0] exp_q[$];

  task automatic load_src(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    src_len = src_rd;
    for (int i = 0; i < n; i++) begin
      src_mem[src_len % 64] = bs[i];
      src_len++;
    end
  endtask

  task automatic run_frame(input string tag, input int cnt, input logic ss, input bit restart_mid);
    int t0, h0, d0, e0, cyc;
    bit fin;
    @(negedge sys_clk);
    t0 = trig_cnt; h0 = hs_cnt; d0 = done_cnt; e0 = errp_cnt; f_log0 = dig_log.size();
    byte_count = CNT_W'(cnt);
    stop_sel   = ss;
    start      = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
      if (restart_mid && cyc == 40) begin
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cyc++;
      end
      if (done_cnt != d0 || errp_cnt != e0) fin = 1'b1;
    end
    check({tag, "_finished"}, 64'(fin), 64'd1);
    f_trig = trig_cnt - t0; f_hs = hs_cnt - h0; f_done = done_cnt - d0;
    f_errp = errp_cnt - e0; f_cycles = cyc;
    $display("[TB] frame %s: count=%0d triggers=%0d handshakes=%0d done=%0d err_pulse=%0d err=%b cycles=%0d",
             tag, cnt, f_trig, f_hs, f_done, f_errp, last_err, f_cycles);
  endtask

  task automatic check_digits(input string tag);
    logic [63:0] g, e;
    int n;
    n = dig_log.size() - f_log0;
    g = '0;
    e = '0;
    for (int i = 0; i < n && i < 32; i++) g = {g[61:0], dig_log[f_log0 + i]};
    for (int i = 0; i < exp_q.size() && i < 32; i++) e = {e[61:0], exp_q[i]};
    check({tag, "_ndig"}, 64'(n), 64'(exp_q.size()));
    check({tag, "_digits"}, g, e);
  endtask

  task automatic push_byte_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, b[i]});
  endtask

  initial begin
    int t0;
    bit ok;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", 64'({in_ready, bit_trigger, busy, done, err_pulse, err, bit_digit}),
          64'(9'b0_0_0_0_0_00_01));
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: one byte A5, console stop
    load_src(1, 8'hA5, 8'h00, 8'h00);
    run_frame("t1", 1, 1'b0, 1'b0);
    exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
    check_digits("t1");
    check("t1_triggers", 64'(f_trig), 64'd9);
    check("t1_done", 64'(f_done), 64'd1);
    check("t1_err_pulse", 64'(f_errp), 64'd0);
    check("t1_err", 64'(last_err), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: three bytes streamed back to back, controller stop
    repeat (3) @(negedge sys_clk);
    load_src(3, 8'h00, 8'hFF, 8'h5A);
    run_frame("t2", 3, 1'b1, 1'b0);
    exp_q = {};
    push_byte_bits(8'h00);
    push_byte_bits(8'hFF);
    push_byte_bits(8'h5A);
    exp_q.push_back(2'b11);
    check_digits("t2");
    check("t2_handshakes", 64'(f_hs), 64'd3);
    check("t2_done", 64'(f_done), 64'd1);
    check("t2_err", 64'(last_err), 64'd0);
    check("t2_cycles_ok", 64'(f_cycles >= 25 * 200 && f_cycles <= 25 * 210), 64'd1);

    // 3: second byte withheld -> underrun, stop bit still sent
    repeat (3) @(negedge sys_clk);
    load_src(1, 8'hC3, 8'h00, 8'h00);
    run_frame("t3", 2, 1'b0, 1'b0);
    exp_q = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    check_digits("t3");
    check("t3_err", 64'(last_err), 64'd1);
    check("t3_err_pulse", 64'(f_errp), 64'd1);
    check("t3_done", 64'(f_done), 64'd0);
    check("t3_handshakes", 64'(f_hs), 64'd1);

    // 4: transmitter never responds -> rise timeout
    repeat (3) @(negedge sys_clk);
    tx_en = 1'b0;
    load_src(1, 8'h80, 8'h00, 8'h00);
    t0 = trig_cnt;
    run_frame("t4", 1, 1'b0, 1'b0);
    check("t4_err", 64'(last_err), 64'd2);
    check("t4_err_pulse", 64'(f_errp), 64'd1);
    check("t4_done", 64'(f_done), 64'd0);
    check("t4_fast_abort", 64'(f_cycles <= 12), 64'd1);
    repeat (50) @(negedge sys_clk);
    check("t4_no_more_triggers", 64'(trig_cnt - t0), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    tx_en = 1'b1;

    // 5: stop bit only, start re-pulsed while busy
    repeat (3) @(negedge sys_clk);
    load_src(0, 8'h00, 8'h00, 8'h00);
    t0 = trig_cnt;
    run_frame("t5", 0, 1'b1, 1'b1);
    exp_q = '{2'b11};
    check_digits("t5");
    check("t5_done", 64'(f_done), 64'd1);
    check("t5_err", 64'(last_err), 64'd0);
    repeat (20) @(negedge sys_clk);
    check("t5_restart_ignored_trig", 64'(trig_cnt - t0), 64'd1);
    check("t5_restart_ignored_busy", 64'(busy), 64'd0);
    check("digit_stable_while_busy", 64'(unstable), 64'd0);

    // 6: asynchronous reset during bit 4, then a clean frame
    repeat (3) @(negedge sys_clk);
    load_src(1, 8'hFF, 8'h00, 8'h00);
    t0 = trig_cnt;
    @(negedge sys_clk);
    byte_count = CNT_W'(1);
    stop_sel   = 1'b0;
    start      = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge sys_clk);
      if (trig_cnt - t0 >= 5) ok = 1'b1;
    end
    check("t6_reached_bit4", 64'(ok), 64'd1);
    repeat (50) @(negedge sys_clk);
    check("t6_busy_before_reset", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 64'({in_ready, bit_trigger, busy, done, err_pulse, err, bit_digit}),
          64'(9'b0_0_0_0_0_00_01));
    @(negedge sys_clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge sys_clk);
      if (!bit_busy) ok = 1'b1;
    end
    check("t6_tx_idle", 64'(ok), 64'd1);
    repeat (3) @(negedge sys_clk);
    load_src(1, 8'h3C, 8'h00, 8'h00);
    run_frame("t6", 1, 1'b1, 1'b0);
    exp_q = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11};
    check_digits("t6");
    check("t6_done", 64'(f_done), 64'd1);
    check("t6_err", 64'(last_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
